instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the R-type datapath (DPTR). Owns the program counter and issues one word read per instruction to an external instruction memory with variable latency. Holds the returned word plus its PC in an output register that the datapath consumes through a valid/ready handshake. Accepts a redirect (branch/jump target, computed downstream from ZF) that flushes stale work.

Parameters:
ADDR_W, 32, PC and memory address width in bits
DATA_W, 32, instruction word width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  one-cycle read request pulse to instruction memory
imem_addr  output  ADDR_W  read address; valid while imem_req=1
imem_rvalid  input  1  memory response strobe, at least 1 cycle after imem_req
imem_rdata  input  DATA_W  instruction word; valid while imem_rvalid=1
instr_valid  output  1  instr_out/pc_out hold a live instruction
instr_ready  input  1  datapath accepts instruction this cycle
instr_out  output  DATA_W  fetched instruction
pc_out  output  ADDR_W  address of instr_out
pc_plus4  output  ADDR_W  pc_out + 4, combinational from pc_out
redirect_en  input  1  replace PC and flush
redirect_pc  input  ADDR_W  new PC; bits [1:0] forced to 0 internally

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low. On reset: pc=RESET_PC, state=FETCH, imem_req=0, instr_valid=0, instr_out=0 (NOP), pc_out=0. A reset mid-WAIT abandons the request. Any imem_rvalid in the first cycles after reset is ignored: the state is FETCH, not WAIT.
- Handshake: a transfer occurs when instr_valid & instr_ready. instr_out and pc_out are stable while instr_valid=1 and instr_ready=0.
- At most one outstanding memory request. The slot is "free" when instr_valid=0 or a transfer occurs this cycle.
- FETCH:
  - If redirect_en: pc<=redirect_pc, instr_valid<=0, imem_req=0, stay FETCH.
  - Else, if the slot is free: imem_req=1, imem_addr=pc, go to WAIT. A transfer this cycle clears instr_valid.
  - Else: imem_req=0, stay FETCH.
- WAIT (imem_req=0):
  - redirect_en with imem_rvalid: discard data, pc<=redirect_pc, instr_valid<=0, go to FETCH.
  - redirect_en only: pc<=redirect_pc, instr_valid<=0, go to DROP.
  - imem_rvalid only: instr_out<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+4, go to FETCH.
  - A transfer in WAIT clears instr_valid. The slot is empty on arrival in WAIT by construction.
- DROP (imem_req=0):
  - On imem_rvalid: discard the data, go to FETCH.
  - redirect_en: pc<=redirect_pc, stay DROP; if imem_rvalid is also high, go to FETCH.
- redirect_en has priority over every other event. A transfer in the same cycle as a redirect still counts as consumed.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 wraps to 0.
- Latency: memory latency L gives instr_valid L+1 cycles after the FETCH cycle. Best-case throughput is 1 instruction per 2 cycles (L=1).
- imem_rvalid in FETCH is a protocol error; it is ignored.

Decomposition:
- fetch_pkg holds:
  - state enum {FETCH, WAIT, DROP}, 2 bits;
  - NOP_INSTR = 32'h0000_0000;
  - PC_STEP = 4.
- One sub-module, pc_register: async active-low reset to RESET_PC, load (redirect) over increment (+4) over hold, forcing low 2 bits to 0.
- The FSM, output register and handshake live in instr_fetch_unit.

Test Plan:
1. Reset then L=1 memory returning addr+32'h1000, instr_ready=1 → imem_addr sequence 0,4,8,C on every other cycle; instr_out 32'h1000,32'h1004…; pc_out matches; pc_plus4=pc_out+4.
2. instr_ready=0 for 5 cycles after first instr_valid → instr_out/pc_out stable, no imem_req while held; first imem_req the cycle instr_ready returns to 1.
3. L=3 memory; redirect_en=1, redirect_pc=32'h40 one cycle after imem_req → state DROP; response discarded (instr_valid stays 0); next imem_addr=32'h40.
4. redirect_en coincident with imem_rvalid in WAIT, redirect_pc=32'h83 → data dropped; next imem_addr=32'h80.
5. RESET_PC=32'hFFFF_FFFC → first fetch at 32'hFFFF_FFFC, second at 0.
6. rst_n pulsed low during WAIT, late imem_rvalid arrives → instr_valid=0; next imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_e : fetch FSM state (FETCH, WAIT, DROP)
//   NOP_INSTR     : instruction word presented while no fetch has completed
//   PC_STEP       : byte increment between sequential instructions
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;

endpackage : fetch_pkg

// File: rtl/pc_register.sv
// Program counter register.
//   clk, rst_n : clock, asynchronous active-low reset (loads RESET_PC)
//   load       : replace PC with load_pc (highest priority)
//   load_pc    : redirect target; low two bits are dropped
//   inc        : advance PC by one instruction (modulo 2^ADDR_W)
//   pc         : current program counter, always word aligned
module pc_register
  import fetch_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // Load over increment over hold; every write keeps the PC word aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= {RESET_PC[ADDR_W-1:2], 2'b00};
    end else if (load) begin
      pc <= {load_pc[ADDR_W-1:2], 2'b00};
    end else if (inc) begin
      pc <= pc + ADDR_W'(PC_STEP);
    end
  end

endmodule : pc_register

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read at a time to a
// variable-latency instruction memory and holds the returned word for the
// datapath behind a valid/ready handshake. A redirect flushes stale work.
//   clk, rst_n              : clock, asynchronous active-low reset
//   imem_req, imem_addr     : read request pulse and address (from state, combinational)
//   imem_rvalid, imem_rdata : memory response strobe and word
//   instr_valid/instr_ready : output handshake
//   instr_out, pc_out       : held instruction and its address
//   pc_plus4                : pc_out + 4, combinational
//   redirect_en/redirect_pc : replace PC and drop in-flight work
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc
);

  fetch_state_e      state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [ADDR_W-1:0] pc;
  logic              pc_load, pc_inc;
  logic              req_c;
  logic              transfer;
  logic              slot_free;

  assign transfer  = valid_q & instr_ready;
  assign slot_free = ~valid_q | transfer;

  pc_register #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (pc_load),
    .load_pc(redirect_pc),
    .inc    (pc_inc),
    .pc     (pc)
  );

  // Next-state, output-register and PC control.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    req_c    = 1'b0;

    // A consumed instruction empties the slot unless refilled below.
    if (transfer) valid_d = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (redirect_en) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
        end else if (slot_free) begin
          req_c   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_en) begin
          // Response still owed by memory unless it arrives now; DROP eats it.
          pc_load = 1'b1;
          valid_d = 1'b0;
          state_d = imem_rvalid ? FETCH : DROP;
        end else if (imem_rvalid) begin
          instr_d  = imem_rdata;
          pc_out_d = pc;
          valid_d  = 1'b1;
          pc_inc   = 1'b1;
          state_d  = FETCH;
        end
      end
      DROP: begin
        if (redirect_en) pc_load = 1'b1;
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      valid_q  <= 1'b0;
      instr_q  <= DATA_W'(NOP_INSTR);
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

  // Request is held off while reset is asserted even though FETCH with an
  // empty slot would otherwise issue.
  assign imem_req    = req_c & rst_n;
  assign imem_addr   = pc;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_out_q + ADDR_W'(PC_STEP);

endmodule : instr_fetch_unit
